io_n_bidirectional_sync: RTL and testbench
==========================================

Name: io_n_bidirectional_sync

Overview:
- Parametrised multi-channel successor to the single-pin bidirectional IO BEL.
- Each channel drives an external pad with tristate control and captures the pad value back into the fabric.
- Capture path adds a multi-stage synchroniser, a glitch filter and registered rise/fall event pulses.
- Sits in W/E/N/S IO tiles as a BEL; pad-side ports are EXTERNAL and go to the top-level entity.

Parameters:
- CHANNELS, 4: number of independent IO channels.
- SYNC_STAGES, 2: flops in the input synchroniser per channel; legal range 2..4.
- FILTER_CYCLES, 4: number of consecutive cycles a synchronised value must hold before Q accepts it; 0 or 1 means no filtering (1-cycle stage).
- OUT_REG, 1: 1 registers I_top/T_top; 0 makes them combinational.

Ports:
- UserCLK  input  1  fabric user clock; EXTERNAL, SHARED_PORT.
- Reset  input  1  synchronous, active-high reset.
- I  input  CHANNELS  fabric-to-pad data.
- T  input  CHANNELS  tristate control; 1 = pad high-Z.
- O  output  CHANNELS  raw pad value, combinational from O_top.
- Q  output  CHANNELS  synchronised, filtered pad value.
- R  output  CHANNELS  one-cycle pulse when Q rises.
- F  output  CHANNELS  one-cycle pulse when Q falls.
- I_top  output  CHANNELS  pad data; EXTERNAL.
- T_top  output  CHANNELS  pad output-enable (= ~T); EXTERNAL.
- O_top  input  CHANNELS  pad input value; EXTERNAL.

Behaviour:
- Single clock domain: UserCLK. Reset is synchronous and active-high. All channels are identical and independent.
- Reset values: sync chain 0; filter counters 0; Q=0, R=0, F=0.
  - OUT_REG=1: I_top=0 and T_top=0 (pad disabled) while Reset is high and on the first edge after.
- O = O_top. Combinational, unaffected by Reset.
- Output path:
  - OUT_REG=1: I_top<=I and T_top<=~T each edge; 1-cycle latency.
  - OUT_REG=0: I_top=I and T_top=~T combinationally.
- Synchroniser: s = last stage of a SYNC_STAGES-deep shift chain clocked from O_top.
- Filter, per channel: counter cnt, width $clog2(FILTER_CYCLES+1). Each edge:
  - if s==Q: cnt<=0;
  - else if cnt==FILTER_CYCLES-1: Q<=s, cnt<=0;
  - else cnt<=cnt+1.
  - FILTER_CYCLES of 0 or 1: Q<=s every edge.
- Latency from the edge that first samples a new stable O_top value to Q changing: SYNC_STAGES + max(FILTER_CYCLES,1) edges.
- Glitch rejection: a pulse on s lasting fewer than FILTER_CYCLES cycles never reaches Q. The counter clears as soon as s returns to Q.
- Edges:
  - R<=update & s & ~Q; F<=update & ~s & Q, where update is the filter accept condition.
  - R/F are high in the same cycle Q shows its new value, for exactly one cycle.
  - R and F are never simultaneously high on a channel.
- Reset mid-operation: all state clears on the next edge and partial filter counts are lost. If the pad is high at release, Q rises after the full latency, with an R pulse.
- Counter cannot overflow: it saturates by clearing at FILTER_CYCLES-1.

Optional Feature:
- Macro: IO_LOOPBACK_EN.
- Defined:
  - Adds input LoopBack, width CHANNELS.
  - Where LoopBack[n]=1, the synchroniser input for channel n is the internal I_top[n] instead of O_top[n]. This enables fabric self-test without a pad.
  - O is unaffected; it remains O_top.
  - LoopBack is sampled each cycle with no extra latency on the mux.
- Undefined: no LoopBack port; the synchroniser input is always O_top.

Test Plan:
- Reset: hold Reset 3 cycles with O_top=all 1 -> Q=R=F=0 and T_top=0 during reset. After release, Q=all 1 at edge 2+4=6 with a single R pulse.
- Filtered edge: defaults, ch0 O_top 0->1 held -> Q[0] rises exactly 6 edges after first sample, R[0] high 1 cycle. Then 1->0 -> F[0] 1 cycle, 6 edges later.
- Glitch: FILTER_CYCLES=4, O_top[1] high for 3 cycles then low -> Q[1], R[1], F[1] stay 0. A 4-cycle pulse -> Q[1] high for 4 cycles, then R and F pulses.
- Output path: T=0, I=4'b1010, OUT_REG=1 -> I_top=1010 and T_top=1111 one edge later. T=1111 -> T_top=0000. OUT_REG=0 -> same values the same cycle.
- Reset mid-filter: O_top[2] rises, Reset asserted after 2 filter counts -> Q[2]=0. After release, full 6-edge latency restarts.
- IO_LOOPBACK_EN: LoopBack=0001, I[0]=1, O_top[0]=0 -> Q[0]=1 after 1+6 edges (OUT_REG=1) while O[0]=0.

Source files
------------

// File: rtl/io_n_bidirectional_sync.sv
// Multi-channel bidirectional IO BEL: tristate pad drive plus synchronised, filtered capture with edge pulses.
// Optional IO_LOOPBACK_EN adds a LoopBack input that feeds the capture path from the internal I_top.
module io_n_bidirectional_sync #(
    parameter int CHANNELS      = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 4,
    parameter int OUT_REG       = 1
) (
    input  logic                UserCLK,
    input  logic                Reset,
    input  logic [CHANNELS-1:0] I,
    input  logic [CHANNELS-1:0] T,
`ifdef IO_LOOPBACK_EN
    input  logic [CHANNELS-1:0] LoopBack,
`endif
    output logic [CHANNELS-1:0] O,
    output logic [CHANNELS-1:0] Q,
    output logic [CHANNELS-1:0] R,
    output logic [CHANNELS-1:0] F,
    output logic [CHANNELS-1:0] I_top,
    output logic [CHANNELS-1:0] T_top,
    input  logic [CHANNELS-1:0] O_top
);

    localparam int CW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST =
        (FILTER_CYCLES > 1) ? CW'(FILTER_CYCLES - 1) : '0;
    localparam bit FILTER_ON = (FILTER_CYCLES > 1);

    logic [CHANNELS-1:0] sync_in;
    logic [CHANNELS-1:0] s;

    logic [SYNC_STAGES-1:0][CHANNELS-1:0] sync_q, sync_d;
    logic [CHANNELS-1:0][CW-1:0]          cnt_q, cnt_d;
    logic [CHANNELS-1:0]                  q_q, q_d;
    logic [CHANNELS-1:0]                  r_q, r_d;
    logic [CHANNELS-1:0]                  f_q, f_d;

    assign O = O_top;

    // Pad drive path
    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [CHANNELS-1:0] i_top_q, i_top_d;
            logic [CHANNELS-1:0] t_top_q, t_top_d;

            always_comb begin
                i_top_d = I;
                t_top_d = ~T;
            end

            always_ff @(posedge UserCLK) begin
                if (Reset) begin
                    i_top_q <= '0;
                    t_top_q <= '0;
                end else begin
                    i_top_q <= i_top_d;
                    t_top_q <= t_top_d;
                end
            end

            assign I_top = i_top_q;
            assign T_top = t_top_q;
        end else begin : g_out_comb
            assign I_top = I;
            assign T_top = ~T;
        end
    endgenerate

`ifdef IO_LOOPBACK_EN
    assign sync_in = (LoopBack & I_top) | (~LoopBack & O_top);
`else
    assign sync_in = O_top;
`endif

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], sync_in};
    end

    // Filter: a new value must persist FILTER_CYCLES edges before Q takes it
    always_comb begin
        logic upd;
        q_d   = q_q;
        r_d   = '0;
        f_d   = '0;
        cnt_d = cnt_q;
        upd   = 1'b0;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            upd = 1'b0;
            if (!FILTER_ON) begin
                cnt_d[ch] = '0;
                upd       = (s[ch] != q_q[ch]);
            end else if (s[ch] == q_q[ch]) begin
                cnt_d[ch] = '0;
            end else if (cnt_q[ch] == CNT_LAST) begin
                cnt_d[ch] = '0;
                upd       = 1'b1;
            end else begin
                cnt_d[ch] = cnt_q[ch] + CW'(1);
            end
            if (upd) begin
                q_d[ch] = s[ch];
                r_d[ch] = s[ch] & ~q_q[ch];
                f_d[ch] = ~s[ch] & q_q[ch];
            end
        end
    end

    always_ff @(posedge UserCLK) begin
        if (Reset) begin
            sync_q <= '0;
            cnt_q  <= '0;
            q_q    <= '0;
            r_q    <= '0;
            f_q    <= '0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            q_q    <= q_d;
            r_q    <= r_d;
            f_q    <= f_d;
        end
    end

    assign Q = q_q;
    assign R = r_q;
    assign F = f_q;

endmodule

// File: tb/tb_io_n_bidirectional_sync.sv
// Directed bench for io_n_bidirectional_sync: registered and combinational output-path instances.
// Checks reset, filtered latency, glitch rejection, output path, mid-filter reset, loopback.
module tb_io_n_bidirectional_sync;

    logic       clk;
    logic       rst;
    logic [3:0] i_in, t_in, o_top;
    logic [3:0] o, q, r, f, i_top, t_top;
    logic [3:0] o0, q0, r0, f0, i_top0, t_top0;
`ifdef IO_LOOPBACK_EN
    logic [3:0] lb;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    logic [3:0] acc;

    io_n_bidirectional_sync #(
        .CHANNELS(4), .SYNC_STAGES(2), .FILTER_CYCLES(4), .OUT_REG(1)
    ) dut (
        .UserCLK(clk), .Reset(rst), .I(i_in), .T(t_in),
`ifdef IO_LOOPBACK_EN
        .LoopBack(lb),
`endif
        .O(o), .Q(q), .R(r), .F(f),
        .I_top(i_top), .T_top(t_top), .O_top(o_top)
    );

    io_n_bidirectional_sync #(
        .CHANNELS(4), .SYNC_STAGES(2), .FILTER_CYCLES(4), .OUT_REG(0)
    ) dut_comb (
        .UserCLK(clk), .Reset(rst), .I(i_in), .T(t_in),
`ifdef IO_LOOPBACK_EN
        .LoopBack(lb),
`endif
        .O(o0), .Q(q0), .R(r0), .F(f0),
        .I_top(i_top0), .T_top(t_top0), .O_top(o_top)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst   = 1'b1;
        o_top = 4'hF;
        i_in  = 4'h0;
        t_in  = 4'h0;
`ifdef IO_LOOPBACK_EN
        lb    = 4'h0;
`endif
        // Reset held 3 cycles with pad high
        tick(3);
        chk("rst_q", q, 4'h0);
        chk("rst_r", r, 4'h0);
        chk("rst_f", f, 4'h0);
        chk("rst_ttop", t_top, 4'h0);
        chk("rst_itop", i_top, 4'h0);
        rst = 1'b0;
        #1;
        chk("rel_ttop", t_top, 4'h0);
        tick(5);
        chk("rel_q5", q, 4'h0);
        tick(1);
        chk("rel_q6", q, 4'hF);
        chk("rel_r6", r, 4'hF);
        tick(1);
        chk("rel_r7", r, 4'h0);
        chk("rel_q7", q, 4'hF);

        // All pads fall together
        o_top = 4'h0;
        tick(5);
        chk("fall_q5", q, 4'hF);
        tick(1);
        chk("fall_f6", f, 4'hF);
        chk("fall_q6", q, 4'h0);
        tick(1);
        chk("fall_f7", f, 4'h0);

        // Channel 0 filtered rise then fall
        o_top = 4'h1;
        tick(5);
        chk("c0_q5", q, 4'h0);
        tick(1);
        chk("c0_q6", q, 4'h1);
        chk("c0_r6", r, 4'h1);
        tick(1);
        chk("c0_r7", r, 4'h0);
        o_top = 4'h0;
        tick(5);
        chk("c0f_q5", q, 4'h1);
        tick(1);
        chk("c0f_f6", f, 4'h1);
        chk("c0f_q6", q, 4'h0);
        tick(1);
        chk("c0f_f7", f, 4'h0);

        // Raw pass-through
        o_top = 4'h5;
        #1;
        chk("o_pass", o, 4'h5);
        o_top = 4'h0;
        tick(10);

        // 3-cycle glitch on channel 1 is rejected
        acc = 4'h0;
        o_top = 4'h2;
        for (int k = 0; k < 3; k++) begin
            tick(1);
            acc = acc | q | r | f;
        end
        o_top = 4'h0;
        for (int k = 0; k < 10; k++) begin
            tick(1);
            acc = acc | q | r | f;
        end
        chk("glitch3", acc, 4'h0);

        // 4-cycle pulse on channel 1 passes for 4 cycles
        o_top = 4'h2;
        tick(4);
        o_top = 4'h0;
        tick(1);
        chk("p4_q5", q, 4'h0);
        tick(1);
        chk("p4_q6", q, 4'h2);
        chk("p4_r6", r, 4'h2);
        tick(3);
        chk("p4_q9", q, 4'h2);
        chk("p4_r9", r, 4'h0);
        tick(1);
        chk("p4_q10", q, 4'h0);
        chk("p4_f10", f, 4'h2);
        tick(1);
        chk("p4_f11", f, 4'h0);

        // Output path, registered and combinational
        t_in = 4'h0;
        i_in = 4'hA;
        #1;
        chk("comb_itop", i_top0, 4'hA);
        chk("comb_ttop", t_top0, 4'hF);
        tick(1);
        chk("reg_itop", i_top, 4'hA);
        chk("reg_ttop", t_top, 4'hF);
        t_in = 4'hF;
        #1;
        chk("comb_ttop_z", t_top0, 4'h0);
        chk("reg_ttop_hold", t_top, 4'hF);
        tick(1);
        chk("reg_ttop_z", t_top, 4'h0);

        // Reset after two filter counts on channel 2
        o_top = 4'h4;
        tick(4);
        rst = 1'b1;
        tick(1);
        chk("mid_q", q, 4'h0);
        rst = 1'b0;
        tick(5);
        chk("mid_q5", q, 4'h0);
        tick(1);
        chk("mid_q6", q, 4'h4);
        chk("mid_r6", r, 4'h4);

`ifdef IO_LOOPBACK_EN
        // Loopback on channel 0 with pad low
        o_top = 4'h0;
        rst   = 1'b1;
        tick(2);
        rst   = 1'b0;
        lb    = 4'h1;
        i_in  = 4'h1;
        t_in  = 4'h0;
        tick(6);
        chk("lb_q6", q, 4'h0);
        tick(1);
        chk("lb_q7", q, 4'h1);
        chk("lb_o", o, 4'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
